// File: rtl/note_sequencer_if.sv
// Control/data bundle between the front end, the note generator and the sequencer.
// The sequencer is the slave; the front end / generator side is the master.
interface note_sequencer_if #(
    parameter int TEMPO_W = 16,
    parameter int DEPTH   = 8,
    parameter int NOTE_W  = 6
);
    localparam int STEP_W = $clog2(DEPTH);

    logic               start;
    logic               stop;
    logic               mode;
    logic [TEMPO_W-1:0] tempo;
    logic [NOTE_W-1:0]  rng_note;
    logic               rng_pulse;
    logic               rng_en;
    logic [NOTE_W-1:0]  note_out;
    logic               note_valid;
    logic [STEP_W-1:0]  step;
    logic               busy;

    modport master (
        output start, stop, mode, tempo, rng_note,
        input  rng_pulse, rng_en, note_out, note_valid, step, busy
    );

    modport slave (
        input  start, stop, mode, tempo, rng_note,
        output rng_pulse, rng_en, note_out, note_valid, step, busy
    );
endinterface

// File: rtl/note_sequencer.sv
// Tempo-driven step sequencer: pulses the note generator, captures notes into a
// pattern buffer, and either keeps drawing (live) or replays the buffer (loop).
module note_sequencer #(
    parameter int TEMPO_W = 16,
    parameter int DEPTH   = 8,
    parameter int NOTE_W  = 6
) (
    input logic             clk,
    input logic             nrst,
    note_sequencer_if.slave bus
);
    localparam int STEP_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, PLAY} state_t;

    state_t             state_q, state_d;
    logic [TEMPO_W-1:0] cnt_q, cnt_d;
    logic [TEMPO_W-1:0] tempo_q, tempo_d;
    logic               mode_q, mode_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic               valid_q, valid_d;
    logic               pulse_q, pulse_d;
    logic               cap_q, cap_d;
    logic               pat_we;
    logic               tick;
    logic [NOTE_W-1:0]  pat_q [DEPTH];

    assign tick = (cnt_q == tempo_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tempo_d = tempo_q;
        mode_d  = mode_q;
        step_d  = step_q;
        note_d  = note_q;
        valid_d = 1'b0;
        pulse_d = 1'b0;
        cap_d   = 1'b0;
        pat_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FILL;
                    mode_d  = bus.mode;
                    tempo_d = (bus.tempo == '0) ? TEMPO_W'(1) : bus.tempo;
                    cnt_d   = '0;
                    step_d  = '0;
                end
            end
            FILL: begin
                cnt_d = tick ? '0 : cnt_q + TEMPO_W'(1);
                // Capture two cycles after the pulse, once the generator has settled.
                if (cap_q) begin
                    pat_we  = 1'b1;
                    note_d  = bus.rng_note;
                    valid_d = 1'b1;
                    step_d  = step_q + STEP_W'(1);
                    if (mode_q && step_q == STEP_W'(DEPTH - 1)) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end
                end
                pulse_d = tick && (state_d == FILL);
                cap_d   = pulse_q;
            end
            PLAY: begin
                cnt_d = tick ? '0 : cnt_q + TEMPO_W'(1);
                if (tick) begin
                    note_d  = pat_q[step_q];
                    valid_d = 1'b1;
                    step_d  = step_q + STEP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Stop drops everything in flight but keeps the last audible note.
        if (bus.stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            step_d  = '0;
            note_d  = note_q;
            valid_d = 1'b0;
            pulse_d = 1'b0;
            cap_d   = 1'b0;
            pat_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tempo_q <= TEMPO_W'(1);
            mode_q  <= 1'b0;
            step_q  <= '0;
            note_q  <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tempo_q <= tempo_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            note_q  <= note_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            cap_q   <= cap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pat_we) pat_q[step_q] <= bus.rng_note;
    end

    assign bus.rng_pulse  = pulse_q;
    assign bus.rng_en     = (state_q == FILL);
    assign bus.note_out   = note_q;
    assign bus.note_valid = valid_q;
    assign bus.step       = step_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_note_sequencer.sv
// Randomized bench for note_sequencer: expected outputs are computed per cycle from
// the step timing arithmetic (period, capture latency, loop entry) of each run.
module tb_note_sequencer;
    localparam int TEMPO_W = 16;
    localparam int DEPTH   = 8;
    localparam int NOTE_W  = 6;
    localparam int GEN_N   = 1024;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    note_sequencer_if #(.TEMPO_W(TEMPO_W), .DEPTH(DEPTH), .NOTE_W(NOTE_W)) bus ();

    note_sequencer #(.TEMPO_W(TEMPO_W), .DEPTH(DEPTH), .NOTE_W(NOTE_W)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    // Generator stand-in: a fixed random note list, advanced on each enabled pulse.
    logic [NOTE_W-1:0] gen [GEN_N];
    int gidx = 0;
    always @(posedge clk) if (bus.rng_pulse && bus.rng_en) gidx <= gidx + 1;
    assign bus.rng_note = gen[gidx % GEN_N];

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;

    // Reference run description
    bit m_act  = 1'b0;
    bit m_loop = 1'b0;
    int m_s, m_p, m_base;
    int m_pulses = 0;
    logic [NOTE_W-1:0] m_held = '0;

    int e_pulse, e_valid, e_note, e_step, e_busy, e_en;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, n);
        end
    endtask

    task automatic model_eval();
        int c, e_end, nv, d, j;
        if (!m_act) begin
            e_busy = 0; e_en = 0; e_pulse = 0; e_valid = 0; e_step = 0;
            e_note = m_held;
        end else begin
            c     = n - m_s;
            e_end = DEPTH * m_p + 3;
            e_busy = 1;
            if (!m_loop || c <= e_end) begin
                e_en    = (m_loop && c == e_end) ? 0 : 1;
                e_pulse = (c >= m_p + 1 && (c - 1) % m_p == 0 &&
                           (!m_loop || (c - 1) / m_p <= DEPTH)) ? 1 : 0;
                nv      = (c >= 3) ? (c - 3) / m_p : 0;
                e_valid = (c >= m_p + 3 && (c - 3) % m_p == 0) ? 1 : 0;
                e_step  = nv % DEPTH;
                e_note  = (nv > 0) ? gen[(m_base + nv) % GEN_N] : m_held;
            end else begin
                d = c - e_end;
                j = d / m_p;
                e_en    = 0;
                e_pulse = 0;
                e_valid = (d % m_p == 0) ? 1 : 0;
                e_step  = j % DEPTH;
                e_note  = gen[(m_base + ((j == 0) ? DEPTH : ((j - 1) % DEPTH) + 1)) % GEN_N];
            end
        end
    endtask

    task automatic step_cyc(input bit st, input bit sp, input bit md, input int tp, input bit rs);
        @(negedge clk);
        model_eval();
        check("rng_pulse",  bus.rng_pulse,  e_pulse);
        check("note_valid", bus.note_valid, e_valid);
        check("note_out",   bus.note_out,   e_note);
        check("step",       bus.step,       e_step);
        check("busy",       bus.busy,       e_busy);
        check("rng_en",     bus.rng_en,     e_en);
        bus.start = st;
        bus.stop  = sp;
        bus.mode  = md;
        bus.tempo = tp[TEMPO_W-1:0];
        nrst      = !rs;
        if (e_pulse != 0) m_pulses++;
        if (rs) begin
            m_act  = 1'b0;
            m_held = '0;
        end else if (sp) begin
            if (m_act) m_held = e_note[NOTE_W-1:0];
            m_act = 1'b0;
        end else if (st && !m_act) begin
            m_act  = 1'b1;
            m_s    = n;
            m_p    = ((tp == 0) ? 1 : tp) + 1;
            m_loop = md;
            m_base = m_pulses;
        end
        n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step_cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        int tp;
        for (int i = 0; i < GEN_N; i++) gen[i] = NOTE_W'($urandom);
        nrst = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0; bus.tempo = '0;
        repeat (3) @(posedge clk);

        // Idle after reset
        idle(20);

        // Loop mode, tempo 3: fill then two-plus replay loops, then stop
        step_cyc(1, 0, 1, 3, 0);
        idle(110);
        step_cyc(0, 1, 0, 0, 0);
        idle(4);

        // Loop mode, random tempo; a start during FILL must be ignored; reset mid-PLAY
        tp = int'($urandom_range(0, 6));
        step_cyc(1, 0, 1, tp, 0);
        idle(4);
        step_cyc(1, 0, 0, 9, 0);
        idle(DEPTH * (((tp == 0) ? 1 : tp) + 1) * 3);
        step_cyc(0, 0, 0, 0, 1);
        idle(5);

        // Live mode, tempo 0 treated as 1: wrap past DEPTH strobes
        step_cyc(1, 0, 0, 0, 0);
        idle(25);
        // Stop in the cycle right after a generator pulse
        for (int i = 0; i < 20; i++) begin
            step_cyc(0, 0, 0, 0, 0);
            if (e_pulse != 0) break;
        end
        step_cyc(0, 1, 0, 0, 0);
        idle(5);

        // start and stop together from IDLE
        step_cyc(1, 1, 1, 2, 0);
        idle(5);

        // Random live/loop runs stopped at random points
        for (int r = 0; r < 4; r++) begin
            tp = int'($urandom_range(0, 5));
            step_cyc(1, 0, r[0], tp, 0);
            idle(int'($urandom_range(3, 90)));
            step_cyc(0, 1, 0, 0, 0);
            idle(3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Step sequencer that drives the 6-bit random note generator. At a programmable tempo it pulses the generator and captures each new note into a DEPTH-entry pattern buffer, emitting each note with a one-cycle valid strobe. In loop mode it fills the buffer once and then replays it indefinitely without pulsing the generator. In live mode it keeps drawing fresh notes and overwrites the buffer cyclically. It sits between the user-control front end and the waveform/voice stage.

Parameters:
TEMPO_W, 16, width of tempo input (clock cycles per step minus one)
DEPTH, 8, pattern buffer entries; power of 2, at least 2
NOTE_W, 6, note width; must match the generator note output

Ports:
clk  in  1  system clock
nrst  in  1  reset, synchronous active-low
start  in  1  one-cycle request to begin sequencing
stop  in  1  one-cycle request to halt
mode  in  1  0 = live random, 1 = fill-then-loop; sampled on accepted start
tempo  in  TEMPO_W  step period minus one; sampled on accepted start; 0 is treated as 1
rng_note  in  NOTE_W  current note from the generator
rng_pulse  out  1  advance request to the generator, one cycle wide
rng_en  out  1  generator enable; high only in FILL
note_out  out  NOTE_W  current sequenced note; holds between steps
note_valid  out  1  one-cycle strobe, note_out is new
step  out  log2(DEPTH)  buffer index of the next entry to write or play
busy  out  1  high when state != IDLE

Behaviour:
- Reset (nrst=0 at a clk edge): state=IDLE, tick counter=0, step=0, note_out=0, note_valid=0, rng_pulse=0, rng_en=0, busy=0. Buffer contents are not reset; PLAY is reachable only after a complete fill.
- States: IDLE, FILL, PLAY.
- Tick counter: cleared on entering FILL or PLAY. Counts 0..tempo_l, then wraps. The cycle in which counter==tempo_l is the tick. Period is tempo_l+1 cycles.
- IDLE: start=1 -> FILL next cycle. mode_l and tempo_l are latched at that point; step=0, counter=0. start while busy is ignored.
- FILL pipeline, relative to tick cycle T:
  - T+1: rng_pulse=1 (registered).
  - End of T+1: generator updates its note.
  - End of T+2: sequencer samples rng_note into buf[step] and note_out.
  - T+3: note_valid=1 and step has incremented.
  - Captures already in flight complete even if another tick follows.
- FILL wrap:
  - After writing entry DEPTH-1 with mode_l=1 -> PLAY. Entry cycle coincides with the note_valid of the last entry; step=0, counter=0.
  - With mode_l=0, step wraps to 0 and FILL continues, overwriting the oldest entries.
- PLAY: rng_en=0, rng_pulse never asserts. On each tick, note_out <= buf[step] and step increments modulo DEPTH; note_valid=1 in cycle T+1. Loops forever until stop.
- stop=1 in any state -> IDLE next cycle.
  - Pending captures and strobes are discarded: rng_pulse and note_valid are 0 from the next cycle.
  - note_out holds its last value. step resets to 0.
- start and stop in the same cycle: stop wins; stays or becomes IDLE.
- Reset mid-operation overrides everything and yields the reset values above.
- Width rules: step wraps naturally (DEPTH is a power of 2). The tick counter is TEMPO_W bits; tempo_l is max(tempo,1).

Test Plan:
1. Reset then idle 20 cycles, start=0 -> all outputs 0, rng_en=0, busy=0.
2. Timing: start at cycle S, mode=1, tempo=3; bench model returns 1,2,...,8 on successive rng_pulses -> rng_pulse at S+5, S+9, ..., S+33. note_valid at S+7, S+11, ..., S+35 with note_out=1..8. step reads 1..7, then 0 and PLAY at S+35.
3. PLAY continuation of scenario 2 -> no further rng_pulse; note_out replays 1..8 every 4 cycles for at least 2 full loops; rng_en=0.
4. Live mode: mode=0, tempo=0 (treated as 1), model returns 1..10 -> rng_pulse every 2 cycles; 10 note_valid strobes in order. The 9th and 10th strobes carry notes 9 and 10 and leave step=2, showing the wrap and overwrite.
5. Stop: stop asserted in the cycle after an rng_pulse -> IDLE next cycle, that capture produces no note_valid, note_out holds its previous value, step=0, busy=0. start+stop in the same cycle from IDLE stays IDLE.
6. Reset mid-PLAY with nrst=0 for 1 cycle -> reset values on the next cycle. start while busy (in FILL) changes neither mode_l nor the step sequence.
